stonyman_frame_sequencer: RTL and testbench
===========================================

# stonyman_frame_sequencer

Frame-level scheduler for the Stonyman pixel readout path. It walks a ROWS x COLS pixel raster and, for each pixel, hands the row/column address to the Stonyman pixel-select logic and waits for the analog settle time. It then fires one capture request at the ADC controller and waits for its track-complete indication. Conversion of pixel N overlaps selection and settling of pixel N+1. It sits between the MSS frame-control registers and the ADC controller.

## Interface
- ROWS, 112, pixel rows per frame (>= 1)
- COLS, 112, pixel columns per frame (>= 1)
- ADDR_BITS, 7, width of row/col address (2^ADDR_BITS >= max(ROWS, COLS))
- TIMEOUT_COUNTS, 255, maximum cycles spent in WAIT_DONE before the frame is failed (>= 1)

- clk  in  1  system clock, 40 MHz; one clock, all logic on posedge
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle request to capture a frame
- frame_abort  in  1  one-cycle request to terminate the current frame
- settle_counts  in  8  settle cycles after pixel select, sampled on entry to SETTLE
- pix_sel_valid  out  1  pixel address valid toward Stonyman logic
- pix_sel_ready  in  1  Stonyman logic accepts the address
- pix_row  out  ADDR_BITS  current row
- pix_col  out  ADDR_BITS  current column
- adc_capture_start  out  1  one-cycle capture request to the ADC controller
- adc_capture_done  in  1  one-cycle pulse from the ADC controller when tracking ends
- frame_busy  out  1  high from the cycle after start until return to IDLE
- frame_done  out  1  one-cycle pulse after the last pixel's capture_done
- frame_error  out  1  one-cycle pulse on WAIT_DONE timeout
- seq_state  out  3  state test point

## Operation
- All outputs are registered. Reset value of every output is 0, and reset forces the IDLE state. Reset may occur at any cycle, including mid-frame; there is no residual capture pulse after reset.
- The sequencer has six states.
  - IDLE: on frame_start or pending_start, set row=0 and col=0, clear pending_start, go to SELECT. frame_abort is ignored in IDLE.
  - SELECT: hold pix_sel_valid=1 with row/col stable until the cycle pix_sel_ready=1, then go to SETTLE with timer=0. If settle_counts==0, go directly to CAPTURE instead.
  - SETTLE: timer+1 each cycle. When timer >= settle_counts-1, go to CAPTURE.
  - CAPTURE: assert adc_capture_start for exactly one cycle, then go to WAIT_DONE with timer=0.
  - WAIT_DONE: on adc_capture_done, go to ADVANCE. If timer reaches TIMEOUT_COUNTS-1 with no done, pulse frame_error and go to IDLE.
  - ADVANCE: advance the raster position.
    - If col < COLS-1: col+1.
    - Else col=0. If row < ROWS-1: row+1; otherwise this is the last pixel.
    - After a non-last pixel, go to SELECT.
    - After the last pixel, pulse frame_done and go to IDLE. A pending_start then restarts the sequence from IDLE on the next cycle.
- Raster order is row-major. Wrap-around is only col→0 with row+1. Row and col never exceed ROWS-1 and COLS-1.
- frame_start while busy sets pending_start. Any number of extra starts collapse to one.
- frame_abort in any non-IDLE state does the following:
  - Next state is IDLE; pending_start is cleared.
  - No frame_done or frame_error pulse is generated.
  - adc_capture_start is not asserted in the abort cycle.
  - If abort and a capture_done arrive in the same cycle, abort wins.
- frame_start and frame_abort in the same cycle while busy: abort wins and the start is dropped.

## Timing
- frame_start at cycle 0 gives frame_busy=1 and pix_sel_valid=1 at cycle 1.
- Per-pixel minimum, with ready held high and done arriving D cycles after start: 1 (SELECT) + settle_counts (SETTLE) + 1 (CAPTURE) + D (WAIT_DONE) + 1 (ADVANCE).
- frame_done rises the cycle after ADVANCE of the last pixel is decided; frame_busy falls in the same cycle.
- The ADC conversion (ZEROS/READ_BITS, about 30 cycles) runs in parallel with the next SELECT/SETTLE. The sequencer does not observe the ADC FIFO; backpressure reaches it only through a delayed adc_capture_done.

## Structure
- Shared package stonyman_pkg holds:
  - the state encoding (SEQ_IDLE=0, SEQ_SELECT=1, SEQ_SETTLE=2, SEQ_CAPTURE=3, SEQ_WAIT_DONE=4, SEQ_ADVANCE=5);
  - the 3-bit state width;
  - the 8-bit timer width;
  - the default ROWS, COLS and ADDR_BITS values.
- One sub-module, seq_timer: an 8-bit up-counter with clear, enable and compare-to-limit. It is shared between SETTLE and WAIT_DONE, since they are mutually exclusive.

## Test plan
- ROWS=2, COLS=3, settle=2, ready tied high, done 5 cycles after each start → 6 start pulses at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). Exactly one frame_done, and frame_busy low the same cycle.
- pix_sel_ready low for 4 cycles at pixel (0,1) → pix_sel_valid held 5 cycles, address stable, no capture pulse until after the handshake.
- settle_counts=0 → CAPTURE immediately follows the SELECT handshake cycle; settle_counts=255 → exactly 255 SETTLE cycles.
- adc_capture_done withheld, TIMEOUT_COUNTS=16 → frame_error pulse after 16 WAIT_DONE cycles, return to IDLE, no frame_done.
- frame_start during pixel 2, then later frame_abort during WAIT_DONE → IDLE next cycle, pending cleared, no second frame. A separate run without abort gives a second frame starting the cycle after frame_done.
- reset asserted in SETTLE and in CAPTURE → all outputs 0 next cycle, state IDLE, no stray adc_capture_start.

Source files
------------

// File: rtl/stonyman_pkg.sv
// Shared definitions for the Stonyman frame sequencer: state encoding, widths and default geometry.
package stonyman_pkg;

  localparam int unsigned SEQ_STATE_W        = 3;
  localparam int unsigned SEQ_TIMER_W        = 8;
  localparam int unsigned DEF_ROWS           = 112;
  localparam int unsigned DEF_COLS           = 112;
  localparam int unsigned DEF_ADDR_BITS      = 7;
  localparam int unsigned DEF_TIMEOUT_COUNTS = 255;

  typedef logic [SEQ_STATE_W-1:0] seq_state_t;

  localparam logic [SEQ_STATE_W-1:0] SEQ_IDLE      = 3'd0;
  localparam logic [SEQ_STATE_W-1:0] SEQ_SELECT    = 3'd1;
  localparam logic [SEQ_STATE_W-1:0] SEQ_SETTLE    = 3'd2;
  localparam logic [SEQ_STATE_W-1:0] SEQ_CAPTURE   = 3'd3;
  localparam logic [SEQ_STATE_W-1:0] SEQ_WAIT_DONE = 3'd4;
  localparam logic [SEQ_STATE_W-1:0] SEQ_ADVANCE   = 3'd5;

endpackage

// File: rtl/seq_timer.sv
// Saturating up-counter with clear/enable; hit_c flags count >= limit.
module seq_timer
  import stonyman_pkg::*;
#(
  parameter int unsigned W = SEQ_TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         hit_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit_c = (count_q >= limit);

endmodule

// File: rtl/stonyman_frame_sequencer.sv
// Walks the pixel raster: select, settle, fire one ADC capture, wait for track-done, advance.
module stonyman_frame_sequencer
  import stonyman_pkg::*;
#(
  parameter int unsigned ROWS           = DEF_ROWS,
  parameter int unsigned COLS           = DEF_COLS,
  parameter int unsigned ADDR_BITS      = DEF_ADDR_BITS,
  parameter int unsigned TIMEOUT_COUNTS = DEF_TIMEOUT_COUNTS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   frame_abort,
  input  logic [SEQ_TIMER_W-1:0] settle_counts,
  output logic                   pix_sel_valid,
  input  logic                   pix_sel_ready,
  output logic [ADDR_BITS-1:0]   pix_row,
  output logic [ADDR_BITS-1:0]   pix_col,
  output logic                   adc_capture_start,
  input  logic                   adc_capture_done,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic                   frame_error,
  output logic [SEQ_STATE_W-1:0] seq_state
);

  localparam logic [ADDR_BITS-1:0]   ROW_LAST    = ADDR_BITS'(ROWS - 1);
  localparam logic [ADDR_BITS-1:0]   COL_LAST    = ADDR_BITS'(COLS - 1);
  localparam logic [SEQ_TIMER_W-1:0] TIMEOUT_LIM = SEQ_TIMER_W'(TIMEOUT_COUNTS - 1);

  seq_state_t             state_q, state_d;
  logic [ADDR_BITS-1:0]   row_q, row_d;
  logic [ADDR_BITS-1:0]   col_q, col_d;
  logic                   pending_q, pending_d;
  logic [SEQ_TIMER_W-1:0] settle_q, settle_d;
  logic                   pix_sel_valid_q, pix_sel_valid_d;
  logic                   adc_capture_start_q, adc_capture_start_d;
  logic                   frame_busy_q, frame_busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_error_q, frame_error_d;

  logic                   timer_clr;
  logic                   timer_en;
  logic [SEQ_TIMER_W-1:0] timer_limit;
  logic                   timer_hit_c;

  // One timer serves both SETTLE and WAIT_DONE; it is held cleared elsewhere so each entry starts at 0.
  always_comb begin
    timer_en    = (state_q == SEQ_SETTLE) || (state_q == SEQ_WAIT_DONE);
    timer_clr   = !timer_en;
    timer_limit = (state_q == SEQ_SETTLE) ? (settle_q - SEQ_TIMER_W'(1)) : TIMEOUT_LIM;
  end

  seq_timer #(.W(SEQ_TIMER_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .limit (timer_limit),
    .hit_c (timer_hit_c)
  );

  // Next-state, raster position and pulse generation.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    pending_d     = pending_q;
    settle_d      = settle_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;

    if ((state_q != SEQ_IDLE) && frame_start) begin
      pending_d = 1'b1;
    end

    case (state_q)
      SEQ_IDLE: begin
        if (frame_start || pending_q) begin
          row_d     = '0;
          col_d     = '0;
          pending_d = 1'b0;
          state_d   = SEQ_SELECT;
        end
      end
      SEQ_SELECT: begin
        if (pix_sel_ready) begin
          settle_d = settle_counts;
          state_d  = (settle_counts == '0) ? SEQ_CAPTURE : SEQ_SETTLE;
        end
      end
      SEQ_SETTLE: begin
        if (timer_hit_c) begin
          state_d = SEQ_CAPTURE;
        end
      end
      SEQ_CAPTURE: begin
        state_d = SEQ_WAIT_DONE;
      end
      SEQ_WAIT_DONE: begin
        if (adc_capture_done) begin
          state_d = SEQ_ADVANCE;
        end else if (timer_hit_c) begin
          frame_error_d = 1'b1;
          state_d       = SEQ_IDLE;
        end
      end
      SEQ_ADVANCE: begin
        if (col_q < COL_LAST) begin
          col_d   = col_q + ADDR_BITS'(1);
          state_d = SEQ_SELECT;
        end else begin
          col_d = '0;
          if (row_q < ROW_LAST) begin
            row_d   = row_q + ADDR_BITS'(1);
            state_d = SEQ_SELECT;
          end else begin
            frame_done_d = 1'b1;
            state_d      = SEQ_IDLE;
          end
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    // Abort overrides everything, including a coincident capture_done or start.
    if (frame_abort && (state_q != SEQ_IDLE)) begin
      state_d       = SEQ_IDLE;
      pending_d     = 1'b0;
      row_d         = row_q;
      col_d         = col_q;
      frame_done_d  = 1'b0;
      frame_error_d = 1'b0;
    end

    pix_sel_valid_d     = (state_d == SEQ_SELECT);
    adc_capture_start_d = (state_d == SEQ_CAPTURE);
    frame_busy_d        = (state_d != SEQ_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= SEQ_IDLE;
      row_q               <= '0;
      col_q               <= '0;
      pending_q           <= 1'b0;
      settle_q            <= '0;
      pix_sel_valid_q     <= 1'b0;
      adc_capture_start_q <= 1'b0;
      frame_busy_q        <= 1'b0;
      frame_done_q        <= 1'b0;
      frame_error_q       <= 1'b0;
    end else begin
      state_q             <= state_d;
      row_q               <= row_d;
      col_q               <= col_d;
      pending_q           <= pending_d;
      settle_q            <= settle_d;
      pix_sel_valid_q     <= pix_sel_valid_d;
      adc_capture_start_q <= adc_capture_start_d;
      frame_busy_q        <= frame_busy_d;
      frame_done_q        <= frame_done_d;
      frame_error_q       <= frame_error_d;
    end
  end

  assign pix_sel_valid     = pix_sel_valid_q;
  assign pix_row           = row_q;
  assign pix_col           = col_q;
  assign adc_capture_start = adc_capture_start_q;
  assign frame_busy        = frame_busy_q;
  assign frame_done        = frame_done_q;
  assign frame_error       = frame_error_q;
  assign seq_state         = state_q;

endmodule

// File: tb/tb_stonyman_frame_sequencer.sv
// Scoreboard bench for stonyman_frame_sequencer on a 2x3 raster with a 16-cycle done timeout.
module tb_stonyman_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       frame_abort = 1'b0;
  logic [7:0] settle_counts = 8'd2;
  logic       pix_sel_ready = 1'b1;
  logic       adc_capture_done = 1'b0;
  logic       pix_sel_valid;
  logic [6:0] pix_row;
  logic [6:0] pix_col;
  logic       adc_capture_start;
  logic       frame_busy;
  logic       frame_done;
  logic       frame_error;
  logic [2:0] seq_state;

  stonyman_frame_sequencer #(
    .ROWS(2), .COLS(3), .ADDR_BITS(7), .TIMEOUT_COUNTS(16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .frame_start       (frame_start),
    .frame_abort       (frame_abort),
    .settle_counts     (settle_counts),
    .pix_sel_valid     (pix_sel_valid),
    .pix_sel_ready     (pix_sel_ready),
    .pix_row           (pix_row),
    .pix_col           (pix_col),
    .adc_capture_start (adc_capture_start),
    .adc_capture_done  (adc_capture_done),
    .frame_busy        (frame_busy),
    .frame_done        (frame_done),
    .frame_error       (frame_error),
    .seq_state         (seq_state)
  );

  typedef struct {
    int kind;  // 0 capture, 1 frame_done, 2 frame_error
    int row;
    int col;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  done_en = 1'b1;
  int  done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int r, input int c, input int at);
    ev_t e;
    e = '{kind, r, c, at};
    sb.push_back(e);
  endtask

  // Unstalled frame: pixel p captures at s+2+settle+p*(settle+8), done at s+6*(settle+8)+1.
  task automatic push_frame(input int s, input int settle);
    for (int p = 0; p < 6; p++) push_ev(0, p / 3, p % 3, s + 2 + settle + p * (settle + 8));
    push_ev(1, 0, 0, s + 6 * (settle + 8) + 1);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(output int s);
    s = cyc;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(pix_sel_valid), 0);
    check({tag, "_cap"}, int'(adc_capture_start), 0);
    check({tag, "_busy"}, int'(frame_busy), 0);
    check({tag, "_done"}, int'(frame_done), 0);
    check({tag, "_err"}, int'(frame_error), 0);
    check({tag, "_state"}, int'(seq_state), 0);
    check({tag, "_row"}, int'(pix_row), 0);
    check({tag, "_col"}, int'(pix_col), 0);
  endtask

  task automatic handle_ev(input int kind, input int r, input int c);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_event_kind", kind, -1);
    end else begin
      e = sb.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_cycle", cyc, e.cyc);
      if (kind == 0) begin
        check("cap_row", r, e.row);
        check("cap_col", c, e.col);
      end else begin
        check("busy_at_end", int'(frame_busy), 0);
      end
    end
  endtask

  // ADC model: capture_done pulses 5 cycles after each capture request.
  initial forever begin
    @(posedge clk);
    #1;
    adc_capture_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) adc_capture_done = 1'b1;
    end
    @(negedge clk);
    if (adc_capture_start && done_en) done_cnt = 5;
  end

  // Monitor: every output pulse must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (adc_capture_start) handle_ev(0, int'(pix_row), int'(pix_col));
    if (frame_done) handle_ev(1, 0, 0);
    if (frame_error) handle_ev(2, 0, 0);
  end

  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    goto_cyc(cyc + 2);

    // Plain 2x3 frame, settle 2
    start_frame(s);
    push_frame(s, 2);
    check("t1_busy", int'(frame_busy), 1);
    check("t1_valid", int'(pix_sel_valid), 1);
    goto_cyc(s + 70);
    check("t1_idle", int'(seq_state), 0);
    check("t1_sb_empty", sb.size(), 0);

    // Ready withheld 4 cycles at pixel (0,1)
    start_frame(s);
    push_ev(0, 0, 0, s + 4);
    for (int p = 1; p < 6; p++) push_ev(0, p / 3, p % 3, s + 8 + 10 * p);
    push_ev(1, 0, 0, s + 65);
    goto_cyc(s + 10);
    pix_sel_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      goto_cyc(s + 11 + i);
      if (i == 4) pix_sel_ready = 1'b1;
      check("t2_valid_hold", int'(pix_sel_valid), 1);
      check("t2_row_stable", int'(pix_row), 0);
      check("t2_col_stable", int'(pix_col), 1);
      check("t2_no_cap", int'(adc_capture_start), 0);
    end
    goto_cyc(s + 75);
    check("t2_idle", int'(seq_state), 0);
    check("t2_sb_empty", sb.size(), 0);

    // settle_counts = 0: capture right after the handshake
    settle_counts = 8'd0;
    start_frame(s);
    push_frame(s, 0);
    check("t3_select", int'(seq_state), 1);
    goto_cyc(s + 2);
    check("t3_capture", int'(seq_state), 3);
    goto_cyc(s + 55);
    check("t3_sb_empty", sb.size(), 0);

    // settle_counts = 255: exactly 255 SETTLE cycles
    settle_counts = 8'd255;
    start_frame(s);
    push_frame(s, 255);
    goto_cyc(s + 2);
    check("t3b_settle_first", int'(seq_state), 2);
    goto_cyc(s + 256);
    check("t3b_settle_last", int'(seq_state), 2);
    goto_cyc(s + 257);
    check("t3b_capture", int'(seq_state), 3);
    goto_cyc(s + 1590);
    check("t3b_sb_empty", sb.size(), 0);
    settle_counts = 8'd2;

    // Timeout: no capture_done
    done_en = 1'b0;
    start_frame(s);
    push_ev(0, 0, 0, s + 4);
    push_ev(2, 0, 0, s + 21);
    goto_cyc(s + 20);
    check("t4_wait_last", int'(seq_state), 4);
    goto_cyc(s + 21);
    check("t4_idle", int'(seq_state), 0);
    goto_cyc(s + 30);
    check("t4_sb_empty", sb.size(), 0);
    done_en = 1'b1;

    // Pending start, then abort coincident with capture_done
    start_frame(s);
    for (int p = 0; p < 4; p++) push_ev(0, p / 3, p % 3, s + 4 + 10 * p);
    goto_cyc(s + 22);
    frame_start = 1'b1;
    goto_cyc(s + 23);
    frame_start = 1'b0;
    goto_cyc(s + 39);
    frame_abort = 1'b1;
    goto_cyc(s + 40);
    frame_abort = 1'b0;
    check("t5_abort_state", int'(seq_state), 0);
    check("t5_abort_busy", int'(frame_busy), 0);
    goto_cyc(s + 60);
    check("t5_no_restart_state", int'(seq_state), 0);
    check("t5_no_restart_busy", int'(frame_busy), 0);
    check("t5_sb_empty", sb.size(), 0);

    // Pending start without abort: second frame follows frame_done
    start_frame(s);
    push_frame(s, 2);
    goto_cyc(s + 22);
    frame_start = 1'b1;
    goto_cyc(s + 23);
    frame_start = 1'b0;
    push_frame(s + 61, 2);
    goto_cyc(s + 61);
    check("t6_busy_low", int'(frame_busy), 0);
    goto_cyc(s + 62);
    check("t6_restart_busy", int'(frame_busy), 1);
    check("t6_restart_valid", int'(pix_sel_valid), 1);
    check("t6_restart_col", int'(pix_col), 0);
    goto_cyc(s + 130);
    check("t6_sb_empty", sb.size(), 0);

    // Reset during SETTLE
    start_frame(s);
    goto_cyc(s + 2);
    check("t7_in_settle", int'(seq_state), 2);
    reset = 1'b1;
    goto_cyc(s + 3);
    reset = 1'b0;
    check_all_zero("t7_settle_rst");
    goto_cyc(s + 15);
    check("t7_sb_empty", sb.size(), 0);

    // Reset during CAPTURE
    start_frame(s);
    push_ev(0, 0, 0, s + 4);
    goto_cyc(s + 4);
    check("t8_in_capture", int'(seq_state), 3);
    reset = 1'b1;
    goto_cyc(s + 5);
    reset = 1'b0;
    check_all_zero("t8_capture_rst");
    goto_cyc(s + 20);
    check("t8_idle", int'(seq_state), 0);
    check("t8_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
